// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller: default widths,
// sweep mode encodings and the controller state enum.
package dds_pkg;

    localparam int unsigned N_DEFAULT = 8;   // tuning words are N+1 bits
    localparam int unsigned D_DEFAULT = 16;  // dwell counter width

    localparam logic [1:0] MODE_SINGLE   = 2'd0;
    localparam logic [1:0] MODE_REPEAT   = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2
    } state_t;

endpackage

// File: rtl/dds_step_unit.sv
// Combinational frequency stepper: next word toward the target with clamping
// on overshoot (including carry/borrow out of the word), plus end-of-sweep.
// Ports:
//   freq      current frequency word
//   step      unsigned step magnitude
//   target    word the sweep is heading to
//   up        1 = step upward, 0 = step downward
//   next_freq stepped word, clamped to target
//   at_end    current word is the target, or step is zero
module dds_step_unit #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] freq,
    input  logic [W-1:0] step,
    input  logic [W-1:0] target,
    input  logic         up,
    output logic [W-1:0] next_freq,
    output logic         at_end
);

    logic [W:0] sum;
    logic [W:0] diff;

    always_comb begin
        sum    = {1'b0, freq} + {1'b0, step};
        diff   = {1'b0, freq} - {1'b0, step};
        at_end = (freq == target) || (step == '0);
        if (up) begin
            // sum[W] is the carry out of the word
            if (sum[W] || (sum[W-1:0] > target)) next_freq = target;
            else                                 next_freq = sum[W-1:0];
        end else begin
            // diff[W] is the borrow
            if (diff[W] || (diff[W-1:0] < target)) next_freq = target;
            else                                   next_freq = diff[W-1:0];
        end
    end

endmodule

// File: rtl/dds_sweep_controller.sv
// Frequency sweep sequencer for a DDS phase accumulator. Steps the frequency
// word from start to stop, holding each value cfg_dwell+1 cycles, in single,
// repeat or triangle mode, pulsing phase_load at each sweep start.
// Ports:
//   clock, reset         clock, asynchronous active-high reset
//   cfg_valid/cfg_ready  configuration handshake (ready only in IDLE)
//   cfg_*                sweep configuration captured into shadow registers
//   start, abort         begin sweep (IDLE only) / return to IDLE
//   freq_out, phase_out  tuning words to the accumulator
//   phase_load           one-cycle accumulator re-seed pulse
//   busy, done           sweeping / single sweep completed pulse
module dds_sweep_controller
    import dds_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT,
    parameter int unsigned D = D_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [N:0]   cfg_start_freq,
    input  logic [N:0]   cfg_stop_freq,
    input  logic [N:0]   cfg_step,
    input  logic [D-1:0] cfg_dwell,
    input  logic [N:0]   cfg_phase,
    input  logic [1:0]   cfg_mode,
    input  logic         start,
    input  logic         abort,
    output logic [N:0]   freq_out,
    output logic [N:0]   phase_out,
    output logic         phase_load,
    output logic         busy,
    output logic         done
);

    localparam int unsigned W = N + 1;

    state_t         state, state_next;
    logic [W-1:0]   sh_start, sh_stop, sh_step, sh_phase;
    logic [D-1:0]   sh_dwell;
    logic [1:0]     sh_mode;
    logic           cfg_loaded;
    logic           capture;

    logic [W-1:0]   eff_start, eff_stop, eff_phase;
    logic [D-1:0]   eff_dwell;

    logic [D-1:0]   cnt, cnt_next;
    logic           up, up_next;
    logic [W-1:0]   target, target_next, rev_target;
    logic [W-1:0]   freq_next, phase_next;
    logic           phase_load_next, done_next, do_load;

    logic [W-1:0]   fwd_next, rev_next;
    logic           fwd_end, rev_end;

    assign capture = cfg_valid && (state == IDLE);

    // A config offered in the same cycle as start takes effect immediately
    assign eff_start = capture ? cfg_start_freq : sh_start;
    assign eff_stop  = capture ? cfg_stop_freq  : sh_stop;
    assign eff_phase = capture ? cfg_phase      : sh_phase;
    assign eff_dwell = capture ? cfg_dwell      : sh_dwell;

    // Triangle turnaround heads back to whichever endpoint we are not at
    assign rev_target = (target == sh_stop) ? sh_start : sh_stop;

    dds_step_unit #(.W(W)) u_step_fwd (
        .freq      (freq_out),
        .step      (sh_step),
        .target    (target),
        .up        (up),
        .next_freq (fwd_next),
        .at_end    (fwd_end)
    );

    dds_step_unit #(.W(W)) u_step_rev (
        .freq      (freq_out),
        .step      (sh_step),
        .target    (rev_target),
        .up        (!up),
        .next_freq (rev_next),
        .at_end    (rev_end)
    );

    // Shadow configuration registers, written only in IDLE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_start   <= '0;
            sh_stop    <= '0;
            sh_step    <= '0;
            sh_phase   <= '0;
            sh_dwell   <= '0;
            sh_mode    <= MODE_SINGLE;
            cfg_loaded <= 1'b0;
        end else if (capture) begin
            sh_start   <= cfg_start_freq;
            sh_stop    <= cfg_stop_freq;
            sh_step    <= cfg_step;
            sh_phase   <= cfg_phase;
            sh_dwell   <= cfg_dwell;
            sh_mode    <= cfg_mode;
            cfg_loaded <= 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            freq_out   <= '0;
            phase_out  <= '0;
            phase_load <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_ready  <= 1'b1;
            cnt        <= '0;
            up         <= 1'b1;
            target     <= '0;
        end else begin
            state      <= state_next;
            freq_out   <= freq_next;
            phase_out  <= phase_next;
            phase_load <= phase_load_next;
            busy       <= (state_next != IDLE);
            done       <= done_next;
            cfg_ready  <= (state_next == IDLE);
            cnt        <= cnt_next;
            up         <= up_next;
            target     <= target_next;
        end
    end

    // Next-state and output logic; LOAD counts as the first dwell cycle
    always_comb begin
        state_next      = state;
        freq_next       = freq_out;
        phase_next      = phase_out;
        cnt_next        = cnt;
        up_next         = up;
        target_next     = target;
        phase_load_next = 1'b0;
        done_next       = 1'b0;
        do_load         = 1'b0;

        case (state)
            IDLE: begin
                if (start && (cfg_loaded || cfg_valid)) do_load = 1'b1;
            end
            LOAD, DWELL: begin
                state_next = DWELL;
                if (cnt != '0) begin
                    cnt_next = cnt - D'(1);
                end else if (!fwd_end) begin
                    freq_next = fwd_next;
                    cnt_next  = sh_dwell;
                end else begin
                    case (sh_mode)
                        MODE_REPEAT: do_load = 1'b1;
                        MODE_TRIANGLE: begin
                            up_next     = !up;
                            target_next = rev_target;
                            freq_next   = rev_end ? freq_out : rev_next;
                            cnt_next    = sh_dwell;
                        end
                        default: begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase

        if (do_load) begin
            state_next      = LOAD;
            freq_next       = eff_start;
            phase_next      = eff_phase;
            cnt_next        = eff_dwell;
            up_next         = (eff_start <= eff_stop);
            target_next     = eff_stop;
            phase_load_next = 1'b1;
        end

        // Abort wins over everything, including a same-cycle start
        if (abort) begin
            state_next      = IDLE;
            freq_next       = freq_out;
            phase_next      = phase_out;
            cnt_next        = cnt;
            up_next         = up;
            target_next     = target;
            phase_load_next = 1'b0;
            done_next       = 1'b0;
        end
    end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Testbench for dds_sweep_controller: expected per-cycle traces are built from
// the sweep rules as lists of frequency plateaus and compared cycle by cycle.
module tb_dds_sweep_controller;

    localparam int unsigned W = 9;

    logic           clock, reset, cfg_valid, start, abort;
    logic [W-1:0]   cfg_start_freq, cfg_stop_freq, cfg_step, cfg_phase;
    logic [15:0]    cfg_dwell;
    logic [1:0]     cfg_mode;
    logic           cfg_ready, phase_load, busy, done;
    logic [W-1:0]   freq_out, phase_out;

    dds_sweep_controller dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_start_freq (cfg_start_freq),
        .cfg_stop_freq  (cfg_stop_freq),
        .cfg_step       (cfg_step),
        .cfg_dwell      (cfg_dwell),
        .cfg_phase      (cfg_phase),
        .cfg_mode       (cfg_mode),
        .start          (start),
        .abort          (abort),
        .freq_out       (freq_out),
        .phase_out      (phase_out),
        .phase_load     (phase_load),
        .busy           (busy),
        .done           (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Expected per-cycle trace starting at the LOAD cycle
    int ef[$];
    int epl[$];
    int eb[$];
    int ed[$];

    int c_start, c_stop, c_step, c_dwell, c_phase, c_mode;

    task automatic push_plateau(input int v, input int pl);
        for (int i = 0; i <= c_dwell; i++) begin
            ef.push_back(v);
            epl.push_back((pl != 0 && i == 0) ? 1 : 0);
            eb.push_back(1);
            ed.push_back(0);
        end
    endtask

    // One pass of plateaus from a toward b, clamping at b
    task automatic push_pass(input int a, input int b, input int pl, input int skip_first);
        int f;
        f = a;
        if (skip_first == 0) push_plateau(a, pl);
        while (f != b && c_step != 0) begin
            if (a <= b) f = (f + c_step > b) ? b : f + c_step;
            else        f = (f - c_step < b) ? b : f - c_step;
            push_plateau(f, 0);
        end
    endtask

    task automatic build_trace(input int min_len);
        ef.delete(); epl.delete(); eb.delete(); ed.delete();
        if (c_mode == 1) begin
            while (ef.size() < min_len) push_pass(c_start, c_stop, 1, 0);
        end else if (c_mode == 2) begin
            push_pass(c_start, c_stop, 1, 0);
            if (c_start == c_stop || c_step == 0) begin
                while (ef.size() < min_len) push_plateau(c_start, 0);
            end else begin
                while (ef.size() < min_len) begin
                    push_pass(c_stop, c_start, 0, 1);
                    push_pass(c_start, c_stop, 0, 1);
                end
            end
        end else begin
            int last;
            push_pass(c_start, c_stop, 1, 0);
            last = ef[ef.size()-1];
            ef.push_back(last); epl.push_back(0); eb.push_back(0); ed.push_back(1);
            repeat (2) begin
                ef.push_back(last); epl.push_back(0); eb.push_back(0); ed.push_back(0);
            end
        end
    endtask

    task automatic drive_cfg();
        cfg_start_freq = W'(c_start);
        cfg_stop_freq  = W'(c_stop);
        cfg_step       = W'(c_step);
        cfg_dwell      = 16'(c_dwell);
        cfg_phase      = W'(c_phase);
        cfg_mode       = 2'(c_mode);
    endtask

    task automatic set_cfg(input int s, input int e, input int st, input int dw,
                           input int ph, input int md);
        c_start = s; c_stop = e; c_step = st; c_dwell = dw; c_phase = ph; c_mode = md;
    endtask

    task automatic load_cfg(input string name);
        @(negedge clock);
        drive_cfg();
        cfg_valid = 1'b1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s cfg_ready actual=%0b required=1", name, cfg_ready);
        end
        @(negedge clock);
        cfg_valid = 1'b0;
    endtask

    // Pulse start, compare ncyc cycles of the trace, optionally abort afterwards
    task automatic run_sweep(input string name, input int with_cfg, input int ncyc,
                             input int do_abort);
        @(negedge clock);
        if (with_cfg != 0) begin
            drive_cfg();
            cfg_valid = 1'b1;
        end
        start = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clock);
            start     = 1'b0;
            cfg_valid = 1'b0;
            checks++;
            if (freq_out !== W'(ef[i])) begin
                failures++;
                $display("FAIL %s freq cyc=%0d actual=%0d required=%0d", name, i, freq_out, ef[i]);
            end
            checks++;
            if (phase_load !== 1'(epl[i])) begin
                failures++;
                $display("FAIL %s phase_load cyc=%0d actual=%0b required=%0d", name, i, phase_load, epl[i]);
            end
            checks++;
            if (busy !== 1'(eb[i]) || cfg_ready !== 1'(1 - eb[i])) begin
                failures++;
                $display("FAIL %s busy/ready cyc=%0d actual=%0b/%0b required=%0d/%0d",
                         name, i, busy, cfg_ready, eb[i], 1 - eb[i]);
            end
            checks++;
            if (done !== 1'(ed[i])) begin
                failures++;
                $display("FAIL %s done cyc=%0d actual=%0b required=%0d", name, i, done, ed[i]);
            end
            checks++;
            if (phase_out !== W'(c_phase)) begin
                failures++;
                $display("FAIL %s phase cyc=%0d actual=%0d required=%0d", name, i, phase_out, c_phase);
            end
        end
        if (do_abort != 0) begin
            abort = 1'b1;
            @(negedge clock);
            abort = 1'b0;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || phase_load !== 1'b0 || cfg_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s abort busy/done/pl/ready actual=%0b%0b%0b%0b required=0001",
                         name, busy, done, phase_load, cfg_ready);
            end
            checks++;
            if (freq_out !== W'(ef[ncyc-1]) || phase_out !== W'(c_phase)) begin
                failures++;
                $display("FAIL %s abort hold actual=%0d/%0d required=%0d/%0d",
                         name, freq_out, phase_out, ef[ncyc-1], c_phase);
            end
        end
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if (freq_out !== '0 || phase_out !== '0 || phase_load !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s reset state actual=f%0d p%0d pl%0b b%0b d%0b r%0b required=f0 p0 pl0 b0 d0 r1",
                     name, freq_out, phase_out, phase_load, busy, done, cfg_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        drive_cfg();
        #1;
        check_idle_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_idle_zero("start_no_cfg");
    endtask

    task automatic test_directed();
        set_cfg(10, 40, 10, 2, 33, 0);   load_cfg("single");
        build_trace(0);  run_sweep("single", 0, ef.size(), 0);
        set_cfg(10, 35, 10, 0, 7, 0);    load_cfg("clamp");
        build_trace(0);  run_sweep("clamp", 0, ef.size(), 0);
        set_cfg(500, 511, 20, 1, 9, 0);  load_cfg("carry");
        build_trace(0);  run_sweep("carry", 0, ef.size(), 0);
        set_cfg(200, 190, 7, 0, 300, 0); load_cfg("down");
        build_trace(0);  run_sweep("down", 0, ef.size(), 0);
        set_cfg(200, 190, 7, 0, 301, 2); load_cfg("triangle");
        build_trace(20); run_sweep("triangle", 0, ef.size(), 1);
        set_cfg(0, 4, 2, 0, 5, 1);       load_cfg("repeat");
        build_trace(12); run_sweep("repeat", 0, ef.size(), 1);
        set_cfg(123, 123, 5, 1, 11, 2);  load_cfg("tri_hold");
        build_trace(10); run_sweep("tri_hold", 0, ef.size(), 1);
    endtask

    task automatic test_abort();
        int k;
        k = $urandom_range(1, 9);
        set_cfg(0, 4, 2, 1, 77, 1);      load_cfg("abort_rep");
        build_trace(20); run_sweep("abort_rep", 0, k, 1);
        // cfg_loaded kept: restart without a new config
        build_trace(6);  run_sweep("abort_restart", 0, 6, 1);
        k = $urandom_range(1, 11);
        set_cfg(10, 40, 10, 2, 44, 0);   load_cfg("abort_single");
        build_trace(0);  run_sweep("abort_single", 0, k, 1);
    endtask

    task automatic test_handshake();
        set_cfg(10, 40, 10, 2, 85, 0);   load_cfg("hs_dwell");
        build_trace(0);  run_sweep("hs_dwell", 0, 2, 0);
        cfg_start_freq = 9'd100; cfg_stop_freq = 9'd150; cfg_phase = 9'd1;
        cfg_valid = 1'b1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL hs_ready_busy actual=%0b required=0", cfg_ready);
        end
        @(negedge clock);
        cfg_valid = 1'b0;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        build_trace(0);  run_sweep("hs_not_captured", 0, 4, 1);
        set_cfg(77, 80, 1, 0, 427, 0);
        build_trace(0);  run_sweep("hs_same_cycle", 1, ef.size(), 0);
        @(negedge clock);
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || phase_load !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_start actual=b%0b pl%0b r%0b required=b0 pl0 r1", busy, phase_load, cfg_ready);
        end
    endtask

    task automatic test_random();
        int wc;
        for (int it = 0; it < 16; it++) begin
            set_cfg($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(1, 100),
                    $urandom_range(0, 2), $urandom_range(0, 511), $urandom_range(0, 3));
            wc = it % 2;
            if (wc == 0) load_cfg("rand");
            build_trace(30);
            run_sweep("rand", wc, ef.size(), (c_mode == 1 || c_mode == 2) ? 1 : 0);
        end
    endtask

    task automatic test_async_reset();
        set_cfg(200, 190, 7, 3, 291, 2); load_cfg("async");
        build_trace(10); run_sweep("async", 0, 3, 0);
        #2 reset = 1'b1;
        #1 check_idle_zero("async_reset");
        #1 reset = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_idle_zero("async_start_ignored");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_handshake();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dds_sweep_controller.md
# dds_sweep_controller

Sequencer for the DDS phase accumulator. It owns the accumulator's frequency and phase tuning words and steps the frequency word from a start value to a stop value in fixed increments. Each frequency is held for a programmable dwell time. Sweeps run single-shot, repeating or triangle, and a one-cycle phase-reload pulse re-seeds the accumulator at each sweep start.

## Interface
- N, 8, tuning words are N+1 bits wide ([N:0]), matching the accumulator
- D, 16, dwell counter width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  high only in IDLE
- cfg_start_freq  in  N+1  first frequency word
- cfg_stop_freq  in  N+1  last frequency word
- cfg_step  in  N+1  unsigned increment magnitude
- cfg_dwell  in  D  each frequency is held cfg_dwell+1 cycles
- cfg_phase  in  N+1  phase word loaded at each sweep start
- cfg_mode  in  2  0 single, 1 repeat, 2 triangle, 3 reserved (treated as single)
- start  in  1  begin sweep (sampled in IDLE only)
- abort  in  1  terminate sweep
- freq_out  out  N+1  to accumulator freq_in
- phase_out  out  N+1  to accumulator phase_in
- phase_load  out  1  one-cycle pulse, re-seeds the accumulator with phase_out
- busy  out  1  high in LOAD and DWELL
- done  out  1  one-cycle pulse at completion of a single sweep

## Operation
- **States:**
  - **IDLE:** cfg_ready=1.
  - **LOAD:** one cycle; freq_out=start, phase_out=cfg_phase, phase_load=1, dwell counter=cfg_dwell.
  - **DWELL:** counter decrements each cycle. LOAD counts as the first dwell cycle.
- **Config capture:** cfg_valid&&cfg_ready latches all cfg_* into shadow registers and sets cfg_loaded. Shadow registers are never written outside IDLE.
- **Start:** start in IDLE with cfg_loaded (or with cfg_valid in the same cycle) → LOAD; the newly captured config is used. Start with no config is ignored.
- **Direction:** up if start≤stop, else down. The target is stop.
- **Stepping:** when the counter reaches 0 in DWELL:
  - If freq_out==target: the end of sweep is reached.
  - Otherwise: next = freq_out ± step, clamped to target on overshoot. For up, overshoot includes carry out of N+1 bits; for down, it includes borrow. The counter reloads to cfg_dwell.
- **End of sweep:**
  - single: → IDLE, done=1 for one cycle, freq_out holds stop.
  - repeat: → LOAD.
  - triangle: direction reverses, target swaps to start (or back to stop), state stays DWELL with no phase_load, and the next step is applied immediately.
- **Degenerate configs:** step==0 or start==stop means the end is reached after the first dwell period. Triangle with start==stop holds indefinitely.
- **abort:** any state → IDLE next cycle. freq_out and phase_out hold; no done; cfg_loaded is kept. abort+start in the same cycle: abort wins.

## Timing
- **Reset values:** IDLE; freq_out=0, phase_out=0, phase_load=0, busy=0, done=0, cfg_ready=1, cfg_loaded=0. All outputs are registered.
- **Start latency:** start at cycle t → LOAD at t+1 (busy=1, phase_load=1).
- **Dwell:** each frequency value is visible for exactly cfg_dwell+1 cycles.
- **Single completion:** the final dwell ends at cycle e → at e+1 done=1, busy=0, cfg_ready=1.
- **Repeat:** the cycle after the final dwell is LOAD; there is no gap cycle.
- **Reset mid-sweep:** outputs return to reset values immediately (asynchronous).

## Structure
- Shared package dds_pkg holds:
  - mode encodings MODE_SINGLE/REPEAT/TRIANGLE;
  - the state enum IDLE/LOAD/DWELL;
  - default N and D.
- One sub-module, dds_step_unit (combinational), computes next frequency, clamp and end-of-sweep from freq_out, step, target and direction.

## Test plan
- **Single sweep:** N=8, start=10, stop=40, step=10, dwell=2, start at t0 → freq_out 10 @t1–t3, 20 @t4–t6, 30 @t7–t9, 40 @t10–t12; done @t13; phase_load only @t1.
- **Clamping:**
  - start=10, stop=35, step=10, dwell=0 → 10, 20, 30, 35, done.
  - start=500, stop=511, step=20 → 500, 511 (carry clamp).
- **Down sweep:** start=200, stop=190, step=7, dwell=0 → 200, 193, 190, done. Triangle with the same values → 200, 193, 190, 197, 200, 193… with phase_load only once.
- **Repeat:** start=0, stop=4, step=2, dwell=0 → 0, 2, 4, 0, 2, 4 with phase_load on each 0. abort at any cycle → IDLE next cycle, busy=0, no done, freq_out held.
- **Handshake:**
  - cfg_valid during DWELL → cfg_ready=0, config not captured.
  - start before any config → stays IDLE.
  - cfg_valid+start in the same IDLE cycle → LOAD uses the new values.
  - abort+start together → stays IDLE.
- **Async reset:** asserted mid-DWELL → all outputs 0 and cfg_ready=1 without a clock edge; a following start without new config is ignored.
